ysyx_20020207_ifu_prefetch: RTL and testbench

Parametrised instruction-fetch unit with an in-order prefetch buffer and multiple outstanding AXI read requests. It sits between the PC/redirect logic and the IDU. It fetches sequential instructions ahead of the decoder and delivers them over a valid/ready interface, each tagged with its PC. On a redirect it flushes all buffered and in-flight fetches without breaking AXI handshake rules.

---
 rtl/ysyx_20020207_ifu_prefetch.sv | 140 ++++++++++++++
 tb/tb_ysyx_20020207_ifu_prefetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_20020207_ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch FIFO and up to DEPTH outstanding AXI reads.
// A redirect flushes the FIFO and turns every in-flight read into one whose data is discarded.
module ysyx_20020207_ifu_prefetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              io_master_arready,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [1:0]        io_master_rresp,
    input  logic [DATA_W-1:0] io_master_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_out,
    output logic              inst_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic              err_mem_q  [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d, live_q, live_d, drop_q, drop_d;
    logic              doomed_q, doomed_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;

    logic              ar_hs, r_hs, push, pop, issue;
    logic [CW+1:0]     used;

    assign ar_hs = arvalid_q && io_master_arready;
    assign r_hs  = io_master_rvalid;
    assign pop   = (count_q != '0) && inst_ready && !redirect_valid;
    assign push  = r_hs && (drop_q == '0) && !redirect_valid;

    // Credits: buffered entries, kept and dropped reads, plus the pending AR all reserve a slot.
    assign used  = (CW+2)'(count_q) + (CW+2)'(live_q) + (CW+2)'(drop_q) + (CW+2)'(arvalid_q);
    assign issue = (!arvalid_q || io_master_arready) && (used < (CW+2)'(DEPTH)) &&
                   !redirect_valid;

    always_comb begin
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        doomed_d   = doomed_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (ar_hs) arvalid_d = 1'b0;
        if (issue) begin
            arvalid_d  = 1'b1;
            araddr_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end

        if (redirect_valid) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = live_q + drop_q + CW'(ar_hs) - CW'(r_hs);
            live_d     = '0;
            // An AR already on the bus cannot be withdrawn; its data is dropped once accepted.
            doomed_d   = arvalid_q && !io_master_arready;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
        end else begin
            live_d  = live_q + CW'(ar_hs && !doomed_q) - CW'(r_hs && (drop_q == '0));
            drop_d  = drop_q + CW'(ar_hs && doomed_q) - CW'(r_hs && (drop_q != '0));
            if (ar_hs) doomed_d = 1'b0;
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PW'(1);
                resp_pc_d = resp_pc_q + ADDR_W'(4);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            live_q     <= '0;
            drop_q     <= '0;
            doomed_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= RESET_PC;
                err_mem_q[i]  <= 1'b0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            doomed_q   <= doomed_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            if (push) begin
                inst_mem_q[wr_ptr_q] <= io_master_rdata;
                pc_mem_q[wr_ptr_q]   <= resp_pc_q;
                err_mem_q[wr_ptr_q]  <= (io_master_rresp != 2'b00);
            end
        end
    end

    assign io_master_arvalid = arvalid_q;
    assign io_master_araddr  = araddr_q;
    assign io_master_rready  = 1'b1;
    assign inst_valid        = (count_q != '0);
    assign inst              = inst_mem_q[rd_ptr_q];
    assign pc_out            = pc_mem_q[rd_ptr_q];
    assign inst_err          = err_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ysyx_20020207_ifu_prefetch.sv
// Bench for the prefetching IFU: an in-order AXI memory model plus a reference that expects a
// sequential PC stream restarting at each redirect target, with data derived from the address.
module tb_ysyx_20020207_ifu_prefetch;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              io_master_arready;
    logic              io_master_arvalid;
    logic [ADDR_W-1:0] io_master_araddr;
    logic              io_master_rready;
    logic              io_master_rvalid;
    logic [1:0]        io_master_rresp;
    logic [DATA_W-1:0] io_master_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc_out;
    logic              inst_err;

    ysyx_20020207_ifu_prefetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .io_master_arready (io_master_arready),
        .io_master_arvalid (io_master_arvalid),
        .io_master_araddr  (io_master_araddr),
        .io_master_rready  (io_master_rready),
        .io_master_rvalid  (io_master_rvalid),
        .io_master_rresp   (io_master_rresp),
        .io_master_rdata   (io_master_rdata),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst              (inst),
        .pc_out            (pc_out),
        .inst_err          (inst_err)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    int          p_arready, p_rvalid, p_ready, p_redir;
    logic        force_pc_en;
    logic [31:0] force_pc;
    logic [31:0] mem_q [$];
    logic [31:0] exp_pc;
    int          ar_count;
    int          pops;
    logic        pend_q;
    logic [31:0] pend_addr_q;

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic f_err(input logic [31:0] a);
        return (a[6:2] == 5'd1) || (a[6:2] == 5'd13);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_knobs(input int ar, input int rv, input int rd, input int rdir);
        p_arready = ar;
        p_rvalid  = rv;
        p_ready   = rd;
        p_redir   = rdir;
    endtask

    // Called at a falling edge: drive inputs, advance the models, then step one clock.
    task automatic cycle();
        logic rhs, arhs, pop;
        logic [31:0] rp;
        if (pend_q) begin
            chk("ar_hold_valid", 32'(io_master_arvalid), 32'd1);
            chk("ar_hold_addr", io_master_araddr, pend_addr_q);
        end
        io_master_arready = ($urandom_range(99) < p_arready);
        inst_ready        = ($urandom_range(99) < p_ready);
        redirect_valid    = ($urandom_range(99) < p_redir);
        case ($urandom_range(3))
            0:       rp = 32'h8000_0100;
            1:       rp = 32'hFFFF_FFF8;
            default: rp = $urandom & 32'hFFFF_FFFC;
        endcase
        redirect_pc = force_pc_en ? force_pc : rp;
        rhs = (mem_q.size() > 0) && ($urandom_range(99) < p_rvalid);
        io_master_rvalid = rhs;
        if (rhs) begin
            io_master_rdata = f_inst(mem_q[0]);
            io_master_rresp = f_err(mem_q[0]) ? 2'b10 : 2'b00;
        end else begin
            io_master_rdata = $urandom;
            io_master_rresp = 2'($urandom_range(3));
        end
        arhs = io_master_arvalid && io_master_arready;
        pop  = inst_valid && inst_ready;
        if (rhs) void'(mem_q.pop_front());
        if (arhs) begin
            mem_q.push_back(io_master_araddr);
            ar_count++;
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc;
        end else if (pop) begin
            chk("pop_pc", pc_out, exp_pc);
            chk("pop_inst", inst, f_inst(exp_pc));
            chk("pop_err", 32'(inst_err), 32'(f_err(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (mem_q.size() > DEPTH) chk("inflight_le_depth", mem_q.size(), DEPTH);
        pend_q      = io_master_arvalid && !io_master_arready;
        pend_addr_q = io_master_araddr;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_pc       = '0;
        io_master_arready = 1'b0;
        io_master_rvalid  = 1'b0;
        io_master_rresp   = 2'b00;
        io_master_rdata   = '0;
        inst_ready        = 1'b0;
        force_pc_en       = 1'b0;
        force_pc          = '0;
        mem_q.delete();
        exp_pc   = RESET_PC;
        ar_count = 0;
        pops     = 0;
        pend_q   = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic forced_redirect(input logic [31:0] pc, input int ar);
        int sv_ar;
        sv_ar       = p_arready;
        force_pc_en = 1'b1;
        force_pc    = pc;
        p_arready   = ar;
        p_redir     = 100;
        cycle();
        p_redir     = 0;
        p_arready   = sv_ar;
        force_pc_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40 && !inst_valid; i++) cycle();
        chk(tag, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        set_knobs(0, 0, 0, 0);
        do_reset();
        @(negedge clock);
        chk("rst_arvalid", 32'(io_master_arvalid), 32'd0);
        chk("rst_araddr", io_master_araddr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc_out", pc_out, RESET_PC);
        chk("rst_inst_err", 32'(inst_err), 32'd0);
        chk("rst_rready", 32'(io_master_rready), 32'd1);

        // Startup with zero-wait memory and an always-ready consumer.
        reset = 1'b1;
        set_knobs(100, 100, 100, 0);
        cycle();
        chk("first_arvalid", 32'(io_master_arvalid), 32'd1);
        chk("first_araddr", io_master_araddr, RESET_PC);
        cycle();
        chk("no_bypass", 32'(inst_valid), 32'd0);
        cycle();
        chk("first_inst_valid", 32'(inst_valid), 32'd1);
        chk("first_pc", pc_out, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("stream_valid", 32'(inst_valid), 32'd1);
        end
        chk("stream_pops", pops, 8);

        // Backpressure: exactly DEPTH reads, then silence until the consumer drains.
        do_reset();
        reset = 1'b1;
        set_knobs(100, 100, 0, 0);
        repeat (12) cycle();
        chk("bp_ar_count", ar_count, DEPTH);
        chk("bp_arvalid", 32'(io_master_arvalid), 32'd0);
        chk("bp_head_pc", pc_out, RESET_PC);
        p_ready = 100;
        repeat (10) cycle();
        chk("bp_drain_pops", 32'(pops >= 6), 32'd1);

        // Redirect with three reads in flight, the third accepted in the redirect cycle.
        do_reset();
        reset = 1'b1;
        set_knobs(100, 0, 0, 0);
        repeat (3) cycle();
        forced_redirect(32'h8000_0100, 100);
        chk("r3_inst_valid", 32'(inst_valid), 32'd0);
        set_knobs(100, 100, 0, 0);
        wait_valid("r3_valid");
        chk("r3_first_pc", pc_out, 32'h8000_0100);
        chk("r3_first_inst", inst, f_inst(32'h8000_0100));

        // Redirect while an AR is stalled: it must hold, and its data must be dropped.
        do_reset();
        reset = 1'b1;
        set_knobs(0, 100, 100, 0);
        cycle();
        forced_redirect(32'h8000_0100, 0);
        chk("doom_hold_addr", io_master_araddr, RESET_PC);
        cycle();
        chk("doom_hold_addr2", io_master_araddr, RESET_PC);
        p_arready = 100;
        cycle();
        chk("doom_next_arvalid", 32'(io_master_arvalid), 32'd1);
        chk("doom_next_araddr", io_master_araddr, 32'h8000_0100);
        wait_valid("doom_valid");
        chk("doom_first_pc", pc_out, 32'h8000_0100);

        // Error response on the second fetch travels with its entry.
        do_reset();
        reset = 1'b1;
        set_knobs(100, 100, 100, 0);
        repeat (4) cycle();
        chk("err_pc", pc_out, 32'h8000_0004);
        chk("err_flag", 32'(inst_err), 32'd1);
        cycle();
        chk("err_next_pc", pc_out, 32'h8000_0008);
        chk("err_next_flag", 32'(inst_err), 32'd0);

        // Redirect coinciding with a pop and an R handshake.
        repeat (3) cycle();
        forced_redirect(32'h8000_0200, 100);
        chk("rpr_inst_valid", 32'(inst_valid), 32'd0);
        wait_valid("rpr_valid");
        chk("rpr_first_pc", pc_out, 32'h8000_0200);

        // Randomised traffic, redirects included (some wrap past the top of memory).
        do_reset();
        reset = 1'b1;
        set_knobs(70, 60, 70, 3);
        repeat (3000) cycle();
        set_knobs(100, 100, 100, 0);
        repeat (30) cycle();
        chk("rand_mem_drained", 32'(mem_q.size() <= 1), 32'd1);
        chk("rand_streaming", 32'(inst_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
